// File: rtl/qq_pkg.sv
// Shared types for the QuickQ host-side port.
package qq_pkg;

  localparam int unsigned KEY_W = 8;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENQ_WAIT = 2'd1,
    DEQ_WAIT = 2'd2,
    ERR      = 2'd3
  } qq_host_state_t;

endpackage

// File: rtl/qq_out_buf.sv
// Two-entry FIFO holding dequeued keys until the consumer takes them.
module qq_out_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Qualify read/write against occupancy; a write into a full buffer is legal only alongside a read.
  always_comb begin
    do_rd = rd && (count != 2'd0);
    do_wr = wr && ((count != 2'd2) || do_rd);
  end

  // Storage, pointers and entry count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign valid   = (count != 2'd0);

endmodule

// File: rtl/qq_host_port.sv
// Initiator-side port for the QuickQ sorted queue: arbitrates push/pop streams
// into held enq/deq requests, buffers dequeued keys and watches for protocol faults.
module qq_host_port
  import qq_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 4,
  parameter int unsigned TO_CYC  = 16,
  parameter int unsigned DEQ_PRI = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [W-1:0]           push_data,
  output logic                   push_ready,
  input  logic                   pop_valid,
  output logic                   pop_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  input  logic                   out_ready,
  output logic                   qq_enq,
  output logic                   qq_deq,
  output logic [W-1:0]           qq_din,
  input  logic                   qq_enq_ack,
  input  logic                   qq_deq_ack,
  input  logic [W-1:0]           qq_dout,
  input  logic                   qq_full,
  input  logic                   qq_empty,
  output logic [$clog2(D+1)-1:0] occ,
  output logic                   timeout
);

  localparam int unsigned OCC_W = $clog2(D + 1);
  localparam int unsigned TMR_W = $clog2(TO_CYC + 1);

  qq_host_state_t state;
  logic [TMR_W-1:0] timer;
  logic             rr_pop;
  logic [1:0]       buf_count;
  logic             buf_wr;
  logic             buf_rd;
  logic             occ_full;
  logic             push_elig;
  logic             pop_elig;
  logic             tie;
  logic             pick_pop;
  logic             idle_err;
  logic             grant_push;
  logic             grant_pop;

  // Eligibility, arbitration and fault detection while idle.
  // Flag/count consistency is only judged in IDLE: during a WAIT the queue's
  // flags legitimately move one cycle ahead of the mirror count.
  always_comb begin
    occ_full   = (occ == OCC_W'(D));
    push_elig  = push_valid && !qq_full && !occ_full;
    pop_elig   = pop_valid && !qq_empty && (occ != '0) && (buf_count != 2'd2);
    tie        = push_elig && pop_elig;
    pick_pop   = (DEQ_PRI != 0) ? 1'b1 : rr_pop;
    idle_err   = qq_enq_ack || qq_deq_ack ||
                 (qq_full && !occ_full) || (qq_empty && (occ != '0));
    grant_push = (state == IDLE) && !idle_err && push_elig && !(tie && pick_pop);
    grant_pop  = (state == IDLE) && !idle_err && pop_elig && !(tie && !pick_pop);
    buf_wr     = (state == DEQ_WAIT) && qq_deq_ack && !qq_enq_ack;
    buf_rd     = out_valid && out_ready;
  end

  // Request FSM with wait timer, mirror occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      rr_pop  <= 1'b0;
      occ     <= '0;
      qq_din  <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_err) begin
            timeout <= 1'b1;
            state   <= ERR;
          end else begin
            if (tie && (DEQ_PRI == 0)) begin
              rr_pop <= ~rr_pop;
            end
            if (grant_push) begin
              qq_din <= push_data;
              timer  <= '0;
              state  <= ENQ_WAIT;
            end else if (grant_pop) begin
              timer <= '0;
              state <= DEQ_WAIT;
            end
          end
        end
        ENQ_WAIT: begin
          if (qq_deq_ack) begin
            timeout <= 1'b1;
            state   <= ERR;
          end else if (qq_enq_ack) begin
            if (!occ_full) begin
              occ <= occ + OCC_W'(1);
            end
            state <= IDLE;
          end else if (timer == TMR_W'(TO_CYC - 1)) begin
            timeout <= 1'b1;
            state   <= ERR;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DEQ_WAIT: begin
          if (qq_enq_ack) begin
            timeout <= 1'b1;
            state   <= ERR;
          end else if (qq_deq_ack) begin
            if (occ != '0) begin
              occ <= occ - OCC_W'(1);
            end
            state <= IDLE;
          end else if (timer == TMR_W'(TO_CYC - 1)) begin
            timeout <= 1'b1;
            state   <= ERR;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

  // Requests decode straight from the state register so reset drops them at once.
  assign qq_enq     = (state == ENQ_WAIT);
  assign qq_deq     = (state == DEQ_WAIT);
  assign push_ready = grant_push;
  assign pop_ready  = grant_pop;

  qq_out_buf #(
    .W (W)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (buf_wr),
    .wr_data (qq_dout),
    .rd      (buf_rd),
    .rd_data (out_data),
    .valid   (out_valid),
    .count   (buf_count)
  );

endmodule
